// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
//
// Oversampling UART receiver. It recovers one frame from RX_IN: start bit,
// DATA_WIDTH data bits sent LSB first, an optional parity bit and one stop
// bit. It then reports the result with single-cycle registered pulses.
// prescale, PAR_EN and PAR_TYP are captured when the start bit is detected,
// and they hold for the rest of that frame.
//
// Ports:
//   clk          UART RX clock (prescale x baud)
//   rst          asynchronous active-low reset
//   RX_IN        serial line, idles high, already synchronized
//   prescale     oversampling ratio (8, 16 or 32; anything else acts as 8)
//   PAR_EN       1 = frame carries a parity bit
//   PAR_TYP      0 = even parity, 1 = odd parity
//   P_DATA       last correctly received byte
//   data_valid   one-cycle pulse, P_DATA has just been updated
//   parity_error one-cycle pulse on parity mismatch
//   stop_error   one-cycle pulse when the stop bit was sampled low
// ---------------------------------------------------------------------------
module uart_rx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [5:0]            prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [5:0]            edge_cnt;
  logic [BCW-1:0]        bit_cnt;
  logic [5:0]            prescale_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_err_q;
  logic [2:0]            samples;
  logic [DATA_WIDTH-1:0] shift_q;

  logic [5:0] prescale_sel;
  logic [5:0] half;
  logic [5:0] last_edge;
  logic       sample_now;
  logic       maj;

  // Unsupported ratios fall back to 8 so the counters always have a sane period.
  always_comb begin
    prescale_sel = 6'd8;
    if (prescale == 6'd16 || prescale == 6'd32) begin
      prescale_sel = prescale;
    end
  end

  assign half       = {1'b0, prescale_q[5:1]};
  assign last_edge  = prescale_q - 6'd1;
  assign sample_now = (edge_cnt == half - 6'd1) || (edge_cnt == half) ||
                      (edge_cnt == half + 6'd1);
  // All three mid-bit samples are taken before the bit ends. So at
  // edge_cnt = P-1 the history register holds exactly that bit's samples.
  assign maj = (samples[0] & samples[1]) | (samples[1] & samples[2]) |
               (samples[0] & samples[2]);

  // edge_cnt holds the position within the current bit of the edge being
  // processed. The detecting edge in IDLE is position 0, so START begins
  // counting at 1. The result is registered on the last edge of the stop
  // bit, and the FSM re-enters IDLE on that same edge. This lets the next
  // start bit be caught on the very next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      prescale_q   <= 6'd8;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_err_q    <= 1'b0;
      samples      <= '0;
      shift_q      <= '0;
      P_DATA       <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;

      if (state == IDLE) begin
        edge_cnt <= '0;
        if (!RX_IN) begin
          state      <= START;
          edge_cnt   <= 6'd1;
          bit_cnt    <= '0;
          prescale_q <= prescale_sel;
          par_en_q   <= PAR_EN;
          par_typ_q  <= PAR_TYP;
          par_err_q  <= 1'b0;
        end
      end else begin
        if (sample_now) begin
          samples <= {samples[1:0], RX_IN};
        end

        if (edge_cnt != last_edge) begin
          edge_cnt <= edge_cnt + 6'd1;
        end else begin
          edge_cnt <= '0;
          case (state)
            START: begin
              // A start bit that votes high was only a glitch.
              if (maj) begin
                state <= IDLE;
              end else begin
                state <= DATA;
              end
            end
            DATA: begin
              shift_q <= {maj, shift_q[DATA_WIDTH-1:1]};
              bit_cnt <= bit_cnt + BCW'(1);
              if (bit_cnt == LAST_BIT) begin
                state <= par_en_q ? PARITY : STOP;
              end
            end
            PARITY: begin
              par_err_q <= maj ^ (^shift_q) ^ par_typ_q;
              state     <= STOP;
            end
            STOP: begin
              stop_error   <= ~maj;
              parity_error <= par_err_q;
              if (maj && !par_err_q) begin
                data_valid <= 1'b1;
                P_DATA     <= shift_q;
              end
              state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
